call_stack: RTL and testbench



---
 rtl/call_stack.sv | 102 ++++++++++
 tb/tb_call_stack.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// LIFO for the CPU return-address/data stack with a combinational top-of-stack read.
// Define STACK_ERR_EN to build the sticky overflow/underflow flags; otherwise both are tied to 0.
module call_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stack_push_enable,
  input  logic [WIDTH-1:0]           stack_push_data,
  input  logic                       stack_pop_enable,
  output logic [WIDTH-1:0]           stack_pop_data,
  input  logic                       stack_clear,
  output logic [$clog2(DEPTH):0]     stack_count,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_overflow,
  output logic                       stack_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             full, empty;

  assign full    = (sp_q == CW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q[AW-1:0] - AW'(1);

  assign stack_count    = sp_q;
  assign stack_full     = full;
  assign stack_empty    = empty;
  assign stack_pop_data = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[AW-1:0];
    if (stack_clear) begin
      sp_d = '0;
    end else if (stack_push_enable && (!stack_pop_enable || empty)) begin
      // push-and-pop on an empty stack degenerates to a plain push
      if (!full) begin
        wr_en = 1'b1;
        sp_d  = sp_q + ONE;
      end
    end else if (stack_push_enable) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (stack_pop_enable && !empty) begin
      sp_d = sp_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= stack_push_data;
    end
  end

`ifdef STACK_ERR_EN
  logic ovf_q, unf_q;
  logic ovf_set, unf_set;

  assign ovf_set = stack_push_enable && !stack_pop_enable && full  && !stack_clear;
  assign unf_set = stack_pop_enable  && !stack_push_enable && empty && !stack_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (stack_clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
`else
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: driver queues expected outputs from a queue-based model, monitor compares at negedge.
module tb_call_stack;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push_en = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             pop_en = 1'b0;
  logic [WIDTH-1:0] pop_data;
  logic             clr = 1'b0;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, unf;

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .stack_push_enable(push_en), .stack_push_data(push_data),
    .stack_pop_enable(pop_en), .stack_pop_data(pop_data),
    .stack_clear(clr), .stack_count(count),
    .stack_full(full), .stack_empty(empty),
    .stack_overflow(ovf), .stack_underflow(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    logic [7:0] top;
    bit         full;
    bit         empty;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stk[$];
  bit         m_ovf, m_unf;
  int         tests = 0;
  int         fails = 0;

  function automatic exp_t snap();
    exp_t e;
    e.cnt   = stk.size();
    e.top   = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
    e.full  = (stk.size() == DEPTH);
    e.empty = (stk.size() == 0);
    e.ovf   = ERR && m_ovf;
    e.unf   = ERR && m_unf;
    return e;
  endfunction

  function automatic void model_reset();
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step(bit pu, logic [7:0] d, bit po, bit cl);
    if (cl) begin
      model_reset();
    end else if (pu && po && stk.size() > 0) begin
      stk[stk.size()-1] = d;
    end else if (pu) begin
      if (stk.size() < DEPTH) stk.push_back(d);
      else if (!po) m_ovf = 1'b1;
    end else if (po) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_unf = 1'b1;
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",     int'(count),    e.cnt);
        chk("pop_data",  int'(pop_data), int'(e.top));
        chk("full",      int'(full),     int'(e.full));
        chk("empty",     int'(empty),    int'(e.empty));
        chk("overflow",  int'(ovf),      int'(e.ovf));
        chk("underflow", int'(unf),      int'(e.unf));
      end
    end
  end

  task automatic cyc(bit pu, logic [7:0] d, bit po, bit cl);
    @(posedge clk);
    #1;
    push_en = pu; push_data = d; pop_en = po; clr = cl;
    exp_q.push_back(snap());
    if (!rst) model_step(pu, d, po, cl);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // rst rises mid-cycle during a push; outputs must drop before any edge.
  task automatic async_reset_during_push(logic [7:0] d1, logic [7:0] d2);
    @(posedge clk);
    #1;
    push_en = 1'b1; push_data = d1; pop_en = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    exp_q.push_back(snap());
    @(posedge clk);
    #1;
    push_data = d2;
    exp_q.push_back(snap());
    #2 rst = 1'b0;
    model_step(1'b1, d2, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    rst = 1'b0;
    idle();

    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    idle();
    repeat (3) cyc(0, 8'h00, 1, 0);
    idle();

    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h44, 0, 0);
    idle();
    cyc(0, 8'h00, 0, 1);

    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    idle();
    cyc(1, 8'hBB, 1, 0);
    idle();
    cyc(0, 8'h00, 0, 1);

    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h05, 0, 0);
    cyc(1, 8'h77, 1, 0);
    idle();
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h99, 1, 0);
    idle();
    cyc(0, 8'h00, 0, 1);

    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0);
    async_reset_during_push(8'h5F, 8'h60);
    cyc(1, 8'h61, 0, 0);
    cyc(1, 8'h62, 0, 0);
    repeat (4) cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h71, 0, 0);
    cyc(1, 8'h72, 0, 0);
    cyc(1, 8'h73, 0, 0);
    idle();
    cyc(0, 8'h00, 0, 1);
    idle();

    for (int i = 0; i < 400; i++) begin
      bit pu, po, cl;
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 99) < 3);
      cyc(pu, 8'($urandom), po, cl);
    end
    idle();

    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
